// File: rtl/radio_capture_ctrl.sv
// ============================================================================
// Module      : radio_capture_ctrl
// Description : Decimating capture sequencer for the 1-bit per-antenna I/Q
//               bus, presenting samples on a valid/ready stream. Optional
//               RADIO_CAPTURE_TESTPAT_EN replaces radio data with sample index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module radio_capture_ctrl #(
  parameter int NUM_ANT = 24,
  parameter int DECIM   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk16,
  input  logic                   rst_n,
  input  logic [NUM_ANT-1:0]     data_i,
  input  logic [NUM_ANT-1:0]     data_q,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       num_samples,
  output logic [2*NUM_ANT-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int W     = 2 * NUM_ANT;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0] C_DEC_LAST = DEC_W'(DECIM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_ANT-1:0] in_i_q, in_i_d;
  logic [NUM_ANT-1:0] in_q_q, in_q_d;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               valid_q, valid_d;
  logic [W-1:0]       data_q_r, data_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               hs;
  logic               strobe;
  logic [W-1:0]       sample;

`ifdef RADIO_CAPTURE_TESTPAT_EN
  // Pattern word is the index of the strobe being taken, before increment.
  if (W > CNT_W) begin : g_pat_ext
    assign sample = {{(W - CNT_W){1'b0}}, cnt_q};
  end else if (W == CNT_W) begin : g_pat_eq
    assign sample = cnt_q;
  end else begin : g_pat_trunc
    assign sample = cnt_q[W-1:0];
  end
`else
  assign sample = {in_q_q, in_i_q};
`endif

  assign hs     = valid_q & out_ready;
  assign strobe = (state_q == CAPTURE) && (dec_q == '0);

  always_comb begin
    state_d = state_q;
    in_i_d  = data_i;
    in_q_d  = data_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    valid_d = valid_q;
    data_d  = data_q_r;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (num_samples == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = CAPTURE;
              num_d   = num_samples;
              cnt_d   = '0;
              dec_d   = '0;
              ovf_d   = 1'b0;
            end
          end
        end
        CAPTURE: begin
          dec_d = (dec_q == C_DEC_LAST) ? '0 : dec_q + 1'b1;
          if (hs) valid_d = 1'b0;
          if (strobe) begin
            cnt_d = cnt_q + 1'b1;
            // A dropped sample still advances the count so capture length is fixed.
            if (!valid_q || hs) begin
              valid_d = 1'b1;
              data_d  = sample;
            end else begin
              ovf_d = 1'b1;
            end
            if ((cnt_q + 1'b1) == num_q) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!valid_q || hs) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_i_q   <= '0;
      in_q_q   <= '0;
      dec_q    <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      valid_q  <= 1'b0;
      data_q_r <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_i_q   <= in_i_d;
      in_q_q   <= in_q_d;
      dec_q    <= dec_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      data_q_r <= data_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_data  = data_q_r;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire
